// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, 8 data bits, optional parity, 1 or 2 stop bits.
// Latency: accept edge to start bit on TX_OUT is 2 edges; TX_OUT lags the state by one cycle.
// Backpressure: Data_Valid is ignored while busy; the host must hold or re-issue it.
module uart_tx_ctrl #(
    parameter int STOP_BITS = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] P_DATA,
    input  logic       Data_Valid,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic       ser_data,
    input  logic       ser_done,
    output logic       ser_en,
    output logic       busy,
    output logic       TX_OUT
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    state_t state_q, state_d;
    logic   busy_q,   busy_d;
    logic   tx_q,     tx_d;
    // Parity bit already folded with the parity type captured at accept.
    logic   par_q,    par_d;
    logic   par_en_q, par_en_d;

    // Next-state and captured-config logic; config only changes on accept.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        par_d    = par_q;
        par_en_d = par_en_q;
        case (state_q)
            IDLE: begin
                if (Data_Valid) begin
                    state_d  = START;
                    busy_d   = 1'b1;
                    par_en_d = PAR_EN;
                    par_d    = (^P_DATA) ^ PAR_TYP;
                end
            end
            START: state_d = DATA;
            DATA: begin
                // The serializer flags its 8th bit; leave DATA only then.
                if (ser_done) begin
                    state_d = par_en_q ? PARITY : STOP1;
                end
            end
            PARITY: state_d = STOP1;
            STOP1: begin
                if (STOP_BITS == 2) begin
                    state_d = STOP2;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            STOP2: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Line bit selected from the current state, registered so TX_OUT never glitches.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = ser_data;
            PARITY:  tx_d = par_q;
            STOP1:   tx_d = 1'b1;
            STOP2:   tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // State and output registers; reset drives the line idle-high at once.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            tx_q     <= 1'b1;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            tx_q     <= tx_d;
            par_q    <= par_d;
            par_en_q <= par_en_d;
        end
    end

    assign ser_en = (state_q == DATA);
    assign busy   = busy_q;
    assign TX_OUT = tx_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       ser_data;
    logic       ser_done;
    logic       ser_en;
    logic       busy;
    logic       TX_OUT;

    int checks   = 0;
    int failures = 0;

    logic       stray_done;
    logic [7:0] sh;
    logic [2:0] cnt;

    int   a0, a1, lowcnt;
    logic prev_busy;

    uart_tx_ctrl #(.STOP_BITS(2)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .ser_en     (ser_en),
        .busy       (busy),
        .TX_OUT     (TX_OUT)
    );

    always #5 CLK = ~CLK;

    // Behavioural 8-bit serializer: loads on accept, shifts LSB first while enabled.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sh  <= 8'h00;
            cnt <= 3'd0;
        end else if (Data_Valid && !busy) begin
            sh  <= P_DATA;
            cnt <= 3'd0;
        end else if (ser_en) begin
            sh  <= sh >> 1;
            cnt <= cnt + 3'd1;
        end
    end
    assign ser_data = sh[0];
    assign ser_done = (ser_en && (cnt == 3'd7)) || stray_done;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame with a 1-cycle request. exp_par is the hand-computed parity bit.
    // At cycle disturb_at the config inputs are flipped and a 0x3C request is pulsed.
    task automatic send(input logic [7:0] d, input logic pen, input logic ptyp,
                        input logic exp_par, input int exp_len, input int disturb_at);
        logic [11:0] exp;
        int busy_cnt;
        int en_cnt;
        exp = 12'hFFF;
        exp[0] = 1'b0;
        for (int b = 0; b < 8; b++) exp[b+1] = d[b];
        if (pen) exp[9] = exp_par;
        P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        chk("accept_busy", busy, 1);
        chk("accept_tx_idle", TX_OUT, 1);
        busy_cnt = 1;
        en_cnt   = 0;
        for (int i = 0; i < exp_len; i++) begin
            if (i == disturb_at) begin
                PAR_TYP = ~PAR_TYP; PAR_EN = ~PAR_EN;
                P_DATA = 8'h3C; Data_Valid = 1'b1;
            end
            if (i == disturb_at + 1) Data_Valid = 1'b0;
            tick();
            chk($sformatf("tx_d%02h_bit%0d", d, i), TX_OUT, exp[i]);
            if (busy)   busy_cnt++;
            if (ser_en) en_cnt++;
        end
        chk($sformatf("busy_len_d%02h", d), busy_cnt, exp_len);
        chk($sformatf("ser_en_len_d%02h", d), en_cnt, 8);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("idle_tx_d%02h", d), TX_OUT, 1);
            chk($sformatf("idle_busy_d%02h", d), busy, 0);
        end
    endtask

    initial begin
        RST = 1'b0; P_DATA = 8'h00; Data_Valid = 1'b0;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; stray_done = 1'b0;
        tick(); tick();
        chk("rst_tx", TX_OUT, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ser_en", ser_en, 0);
        RST = 1'b1;
        tick();

        // Even parity: 0xA5 has four ones -> parity 0; 12-cycle frame with 2 stops.
        send(8'hA5, 1'b1, 1'b0, 1'b0, 12, -1);
        // Odd parity on 0x01 -> 0; even -> 1.
        send(8'h01, 1'b1, 1'b1, 1'b0, 12, -1);
        send(8'h01, 1'b1, 1'b0, 1'b1, 12, -1);
        // No parity: start, eight 1s, two stops = 11 cycles.
        send(8'hFF, 1'b0, 1'b0, 1'b0, 11, -1);
        // Busy lockout plus config isolation: 0xC3 even -> 0 despite mid-frame flips.
        send(8'hC3, 1'b1, 1'b0, 1'b0, 12, 4);
        // 0x07 odd -> 0; flip during DATA must not change it.
        send(8'h07, 1'b1, 1'b1, 1'b0, 12, 6);

        // Stray ser_done in IDLE is ignored.
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        chk("stray_busy", busy, 0);
        chk("stray_ser_en", ser_en, 0);
        tick();
        chk("stray_tx", TX_OUT, 1);

        // Held Data_Valid: 11-cycle frames, accepts spaced 12 with one idle cycle.
        P_DATA = 8'h81; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        a0 = -1; a1 = -1; lowcnt = 0; prev_busy = busy;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (a1 >= 0 && c == a1 + 1) chk("b2b_start_bit", TX_OUT, 0);
            if (!prev_busy && busy) begin
                if (a0 < 0) a0 = c;
                else if (a1 < 0) a1 = c;
            end
            if (a0 >= 0 && a1 < 0 && !busy) lowcnt++;
            prev_busy = busy;
        end
        Data_Valid = 1'b0;
        chk("b2b_first_accept", a0, 0);
        chk("b2b_spacing", a1 - a0, 12);
        chk("b2b_idle_cycles", lowcnt, 1);
        for (int k = 0; k < 40 && busy; k++) tick();
        chk("b2b_drain_busy", busy, 0);
        tick(); tick();

        // Reset during the 4th DATA bit: 0x5A bit2 = 0 is on the line, reset forces 1.
        P_DATA = 8'h5A; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        tick(); tick(); tick(); tick();
        chk("pre_rst_ser_en", ser_en, 1);
        chk("pre_rst_tx", TX_OUT, 0);
        #1 RST = 1'b0;
        #1;
        chk("mid_rst_tx", TX_OUT, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ser_en", ser_en, 0);
        tick();
        #2 RST = 1'b1;
        tick();
        chk("post_rst_busy", busy, 0);
        // Fresh 0x5A frame: four ones -> even parity 0.
        send(8'h5A, 1'b1, 1'b0, 1'b0, 12, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
